// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared defaults and the round-robin pick helper for the writeback arbiter.
// rr_pick works on a MAX_REQ-wide vector so any NREQ in 2..4 can reuse it.
package regfile_wb_arbiter_pkg;
    localparam int NREQ_DEF   = 2;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int MAX_REQ    = 4;
    localparam int REG_ZERO   = 0;

    // One-hot grant: first valid index at or after ptr, wrapping modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                                   input logic [1:0]         ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] grant;
        logic [2:0]         idx;
        logic               found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= 3'(n)) idx = idx - 3'(n);
            if (k < n && !found && valid_vec[idx[1:0]]) begin
                grant[idx[1:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin grant plus the rotating pointer register.
// Grant is zero during hold or reset; pointer advances past the winner only.
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N = NREQ_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_hold,
    output logic [N-1:0] o_grant
);
    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [MAX_REQ-1:0] w_pick;
    logic [MAX_REQ-1:0] w_gnt;

    always_comb begin
        w_pick    = rr_pick(MAX_REQ'(i_req), 2'(r_ptr), N);
        w_gnt     = (i_hold || rst) ? '0 : w_pick;
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (w_gnt[i]) w_ptr_nxt = (i >= N - 1) ? '0 : PTR_W'(i + 1);
        end
    end

    assign o_grant = w_gnt[N-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ptr <= '0;
        else     r_ptr <= w_ptr_nxt;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources, one write per cycle
// with one-cycle latency, and tracks outstanding destination registers for issue stalls.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic                   hold,
    input  logic                   claim_valid,
    input  logic [ADDR_W-1:0]      claim_add,
    output logic                   regwrite,
    output logic [ADDR_W-1:0]      write_add,
    output logic [DATA_W-1:0]      write_dat,
    output logic [2**ADDR_W-1:0]   pending,
    output logic [7:0]             zero_drops
);
    localparam int NREG = 2**ADDR_W;

    logic [NREQ-1:0]   w_grant;
    logic              w_xfer;
    logic              w_zero;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [NREG-1:0]   w_pend_nxt;

    logic              r_regwrite;
    logic [ADDR_W-1:0] r_write_add;
    logic [DATA_W-1:0] r_write_dat;
    logic [NREG-1:0]   r_pending;
    logic [7:0]        r_zero_drops;

    rr_arbiter #(.N(NREQ)) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .i_req   (req_valid),
        .i_hold  (hold),
        .o_grant (w_grant)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        w_xfer = |(w_grant & req_valid);
        w_zero = (w_sel_addr == ADDR_W'(REG_ZERO));

        // Clear on accept first, then claim: a same-cycle claim is the younger instruction.
        w_pend_nxt = r_pending;
        if (w_xfer) w_pend_nxt[w_sel_addr] = 1'b0;
        if (claim_valid) w_pend_nxt[claim_add] = 1'b1;
        w_pend_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regwrite   <= 1'b0;
            r_write_add  <= '0;
            r_write_dat  <= '0;
            r_pending    <= '0;
            r_zero_drops <= '0;
        end else begin
            r_regwrite <= w_xfer && !w_zero;
            if (w_xfer && !w_zero) begin
                r_write_add <= w_sel_addr;
                r_write_dat <= w_sel_data;
            end
            if (w_xfer && w_zero && r_zero_drops != 8'hff) r_zero_drops <= r_zero_drops + 8'd1;
            r_pending <= w_pend_nxt;
        end
    end

    assign regwrite   = r_regwrite;
    assign write_add  = r_write_add;
    assign write_dat  = r_write_dat;
    assign pending    = r_pending;
    assign zero_drops = r_zero_drops;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: expected writes are queued at grant time and popped when regwrite is seen.
module tb_regfile_wb_arbiter;
    localparam int NREQ   = 2;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   hold;
    logic                   claim_valid;
    logic [ADDR_W-1:0]      claim_add;
    logic                   regwrite;
    logic [ADDR_W-1:0]      write_add;
    logic [DATA_W-1:0]      write_dat;
    logic [31:0]            pending;
    logic [7:0]             zero_drops;

    int tests = 0;
    int fails = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    regfile_wb_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .hold(hold),
        .claim_valid(claim_valid), .claim_add(claim_add),
        .regwrite(regwrite), .write_add(write_add), .write_dat(write_dat),
        .pending(pending), .zero_drops(zero_drops)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every write seen on the port must match the oldest queued one.
    always @(negedge clk) begin
        if (!rst && regwrite) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, write_add, write_dat}, 64'd0);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                check("sb_write", {27'd0, write_add, write_dat}, {27'd0, e});
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        hold = 1'b0; claim_valid = 1'b0; claim_add = '0;

        // Reset state; ready must stay low under reset even with a request up.
        #2;
        req_valid = 2'b01;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_regwrite", 64'(regwrite), 64'd0);
        check("rst_write_add", 64'(write_add), 64'd0);
        check("rst_write_dat", 64'(write_dat), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_zero_drops", 64'(zero_drops), 64'd0);
        req_valid = '0;
        #9 rst = 1'b0;
        step();

        // 1. Single request
        set_req(0, 5'd1, 32'h0000000f);
        req_valid = 2'b01;
        #1;
        check("single_ready", 64'(req_ready), 64'h1);
        exp_q.push_back({5'd1, 32'h0000000f});
        step();
        req_valid = '0;
        check("single_regwrite", 64'(regwrite), 64'd1);
        check("single_write_add", 64'(write_add), 64'd1);
        check("single_write_dat", 64'(write_dat), 64'hf);
        step();
        check("single_regwrite_off", 64'(regwrite), 64'd0);

        // 2. Contention from a fresh pointer
        rst = 1'b1; #1 rst = 1'b0; #1;
        set_req(0, 5'd2, 32'h000000f0);
        set_req(1, 5'd3, 32'h00000f00);
        req_valid = 2'b11;
        #1;
        check("cont_grant1", 64'(req_ready), 64'h1);
        exp_q.push_back({5'd2, 32'h000000f0});
        step();
        check("cont_grant2", 64'(req_ready), 64'h2);
        check("cont_add1", 64'(write_add), 64'd2);
        exp_q.push_back({5'd3, 32'h00000f00});
        req_valid = 2'b10;
        step();
        req_valid = '0;
        check("cont_add2", 64'(write_add), 64'd3);
        check("cont_regwrite2", 64'(regwrite), 64'd1);

        // 3. Hold blocks all grants
        set_req(1, 5'd7, 32'h00000077);
        req_valid = 2'b10;
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("hold_ready", 64'(req_ready), 64'd0);
            step();
            check("hold_regwrite", 64'(regwrite), 64'd0);
        end
        hold = 1'b0;
        #1;
        check("hold_release_ready", 64'(req_ready), 64'h2);
        exp_q.push_back({5'd7, 32'h00000077});
        step();
        req_valid = '0;
        check("hold_release_write", 64'(regwrite), 64'd1);

        // 4. Register zero: acknowledged, dropped, counted with saturation
        set_req(0, 5'd0, 32'hdeadbeef);
        req_valid = 2'b01;
        #1;
        check("zero_ready", 64'(req_ready), 64'h1);
        step();
        check("zero_regwrite", 64'(regwrite), 64'd0);
        check("zero_count1", 64'(zero_drops), 64'd1);
        for (int c = 0; c < 299; c++) @(posedge clk);
        #1;
        req_valid = '0;
        check("zero_saturate", 64'(zero_drops), 64'd255);
        check("zero_regwrite_end", 64'(regwrite), 64'd0);

        // 5. Scoreboard set / clear / same-cycle collision / reg0 claim
        claim_valid = 1'b1; claim_add = 5'd5;
        step();
        claim_valid = 1'b0;
        check("sb_claim5", 64'(pending), 64'h20);
        set_req(1, 5'd5, 32'h00000055);
        req_valid = 2'b10;
        #1;
        check("sb_xfer5_ready", 64'(req_ready), 64'h2);
        exp_q.push_back({5'd5, 32'h00000055});
        step();
        req_valid = '0;
        check("sb_clear5", 64'(pending), 64'h0);
        set_req(1, 5'd6, 32'h00000066);
        req_valid = 2'b10;
        claim_valid = 1'b1; claim_add = 5'd6;
        #1;
        check("sb_collide_ready", 64'(req_ready), 64'h2);
        exp_q.push_back({5'd6, 32'h00000066});
        step();
        req_valid = '0;
        claim_add = 5'd0;
        check("sb_collide_set_wins", 64'(pending), 64'h40);
        step();
        claim_valid = 1'b0;
        check("sb_claim0_ignored", 64'(pending), 64'h40);

        // 6. Async reset with a write in flight
        set_req(0, 5'd9, 32'h00000099);
        req_valid = 2'b01;
        claim_valid = 1'b1; claim_add = 5'd5;
        step();
        req_valid = '0;
        claim_valid = 1'b0;
        check("ar_pre_regwrite", 64'(regwrite), 64'd1);
        check("ar_pre_write_add", 64'(write_add), 64'd9);
        check("ar_pre_pending", 64'(pending), 64'h60);
        #1 rst = 1'b1;
        req_valid = 2'b11;
        #1;
        check("ar_regwrite", 64'(regwrite), 64'd0);
        check("ar_pending", 64'(pending), 64'd0);
        check("ar_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("ar_post_both", 64'(req_ready), 64'h1);
        req_valid = 2'b10;
        #1;
        check("ar_post_req1", 64'(req_ready), 64'h2);
        req_valid = '0;
        step();
        step();
        check("sb_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (regwrite / write_add / write_dat) between NREQ writeback requesters, e.g. ALU writeback and load writeback.
- Uses valid/ready handshakes with round-robin arbitration and a registered write stage.
- Keeps a 32-bit pending-write scoreboard so issue logic can stall on registers with an outstanding write.
- Sits between the writeback sources and the register file.

Parameters:
- NREQ, 2, number of writeback requesters (2..4).
- ADDR_W, 5, register address width; the register file has 2**ADDR_W entries.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  requester i has a write pending.
- req_ready  out  NREQ  requester i is granted this cycle (one-hot or zero).
- req_addr  in  NREQ*ADDR_W  destination register per requester; slice i is bits [i*ADDR_W +: ADDR_W].
- req_data  in  NREQ*DATA_W  write data per requester; slice i is bits [i*DATA_W +: DATA_W].
- hold  in  1  blocks all grants while high (register file busy / test access).
- claim_valid  in  1  issue stage reserves a destination register.
- claim_add  in  ADDR_W  register being reserved.
- regwrite  out  1  write enable to the register file.
- write_add  out  ADDR_W  write address to the register file.
- write_dat  out  DATA_W  write data to the register file.
- pending  out  2**ADDR_W  scoreboard; bit r=1 means register r has an outstanding write.
- zero_drops  out  8  saturating count of accepted writes that targeted register 0.

Behaviour:
- Reset (asynchronous, active-high):
  - regwrite=0, write_add=0, write_dat=0.
  - pending=0, zero_drops=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while rst is high.
- Arbitration (combinational):
  - If hold=0, grant the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[i]=1 only for the granted i; req_ready is all-zero when hold=1 or no request is valid.
  - req_ready must not depend on any registered output of the same cycle beyond rr_ptr.
- Transfer: occurs when req_valid[i] & req_ready[i] at a rising edge.
  - The requester must hold addr/data stable while valid and not ready.
  - A requester may drop valid only after its transfer.
- rr_ptr update: after a transfer from i, rr_ptr <= (i+1) mod NREQ. It is unchanged on cycles with no transfer.
- Write stage, one-cycle latency:
  - On transfer with addr!=0: regwrite<=1, write_add<=addr, write_dat<=data.
  - On transfer with addr==0: regwrite<=0, and zero_drops increments (saturates at 255). The requester is still acknowledged.
  - No transfer: regwrite<=0. write_add and write_dat hold their last value.
  - At most one write per cycle; back-to-back writes are allowed on consecutive cycles.
- Scoreboard:
  - claim_valid with claim_add!=0 sets pending[claim_add] at the edge.
  - A transfer clears pending[addr] at the same edge the transfer is accepted, not when regwrite fires.
  - If a claim and a transfer hit the same register in the same cycle, set wins: the bit stays 1, because the claim is a newer instruction.
  - pending[0] is always 0; claims to register 0 are ignored.
  - A transfer to a register whose pending bit is 0 is legal and leaves the bit at 0.
- Reset mid-operation: any in-flight registered write is discarded (regwrite forced 0 immediately), and the scoreboard clears. Requesters must re-present.
- Simultaneous valid on all requesters: strict rotation. Each requester is served at least once every NREQ transfers.

Decomposition:
- Shared package / header:
  - ADDR_W, DATA_W, NREQ defaults.
  - Constant REG_ZERO = 0.
  - Helper function rr_pick(valid_vec, ptr) returning the one-hot grant.
- One sub-module: rr_arbiter (parameter N), combinational grant from req vector and pointer, plus the pointer register.
- Write stage and scoreboard stay in regfile_wb_arbiter.

Test Plan:
1. Single request:
   - Stimulus: reset, then req0 valid with addr=1, data=32'h0000000f.
   - Required: req_ready[0]=1 in the same cycle; next cycle regwrite=1, write_add=1, write_dat=32'h0000000f; the following cycle regwrite=0.
2. Contention and fairness:
   - Stimulus: req0 (addr=2, data=32'h000000f0) and req1 (addr=3, data=32'h00000f00) held valid together from reset, rr_ptr=0.
   - Required: the grant goes to req0 in cycle 1 and to req1 in cycle 2; write_add sequence 2, 3 on consecutive cycles.
3. Hold:
   - Stimulus: hold=1 for 3 cycles with req1 valid.
   - Required: req_ready=0 and regwrite=0 throughout; grant in the first cycle after hold drops.
4. Register zero:
   - Stimulus: req0 with addr=0, data=32'hdeadbeef.
   - Required: acknowledged, regwrite stays 0, zero_drops goes 0->1; 300 such writes leave zero_drops=255.
5. Scoreboard:
   - Stimulus: claim addr=5, then a req1 transfer to addr=5.
   - Required: pending[5] is 1 after the claim and 0 after the transfer edge.
   - Stimulus: claim addr=6 and transfer to addr=6 in the same cycle.
   - Required: pending[6] stays 1.
6. Async reset:
   - Stimulus: assert rst mid-cycle while regwrite=1 and pending=32'h00000060.
   - Required: regwrite=0 and pending=0 immediately, without waiting for a clock edge; after release, req1 is granted first only if req0 is not valid (rr_ptr=0).
